mem_arb: RTL and testbench

Two-port arbiter and sequencer for the single shared data/instruction memory behind the I-cache and D-cache miss paths. It accepts fill and write-back requests from both caches and issues one access at a time to a fixed-latency memory. It returns read data and a one-cycle completion pulse to the winning requester. The block sits in `proc_hier` between the cache controllers and the memory macro.

---
 rtl/mem_arb.sv | 184 ++++++++++++++++++
 tb/tb_mem_arb.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// mem_arb: two-port arbiter and sequencer for the shared instruction/data memory.
// Requests from the I-cache and D-cache miss paths are served one at a time.
// Each request goes to a fixed-latency memory of MEM_LAT cycles.
// Read data and a one-cycle done pulse return to the side that won arbitration.
// Optional feature: define MEM_ARB_RR_EN to resolve ties round-robin.
// Without MEM_ARB_RR_EN, the D side always wins a tie.
//
//   state | meaning
//   IDLE  | arbitrate i_req/d_req, latch winner's address/data into mem_*
//   BUSY  | mem_en in first cycle, count up to MEM_LAT, capture mem_rdata
//   DONE  | winner's done pulse, return to IDLE unconditionally
module mem_arb #(
  parameter int MEM_LAT = 4,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_done,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // latency compare value; the counter is 4 bits wide and stops here
  localparam logic [3:0] LAT = 4'(MEM_LAT);

  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic          r_win_d;
  logic          r_i_gnt;
  logic          r_d_gnt;
  logic          r_i_done;
  logic          r_d_done;
  logic          r_mem_en;
  logic          r_mem_wr;
  logic          r_busy;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [DW-1:0] r_i_rdata;
  logic [DW-1:0] r_d_rdata;

  logic          w_any;
  logic          w_pick_d;
  logic          w_start;

  assign w_any   = i_req | d_req;
  assign w_start = (r_state == ST_IDLE) & w_any;

`ifdef MEM_ARB_RR_EN
  logic r_last_d;

  // on a tie, the side that lost the previous grant wins this one
  assign w_pick_d = d_req & (~i_req | ~r_last_d);

  // remember the winner of every grant; reset means "I won last" so D takes the first tie
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_d <= 1'b0;
    end else if (w_start) begin
      r_last_d <= w_pick_d;
    end
  end
`else
  // fixed priority: D wins ties, so I can starve under continuous d_req
  assign w_pick_d = d_req;
`endif

  // sequencing FSM with registered grant/done/strobe outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_win_d  <= 1'b0;
      r_i_gnt  <= 1'b0;
      r_d_gnt  <= 1'b0;
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
      r_mem_en <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_mem_en <= 1'b0;
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state  <= ST_BUSY;
            r_busy   <= 1'b1;
            r_win_d  <= w_pick_d;
            r_i_gnt  <= ~w_pick_d;
            r_d_gnt  <= w_pick_d;
            r_mem_en <= 1'b1;
            r_cnt    <= 4'd0;
          end
        end
        ST_BUSY: begin
          if (r_cnt == LAT) begin
            r_state  <= ST_DONE;
            r_i_done <= ~r_win_d;
            r_d_done <= r_win_d;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_i_gnt <= 1'b0;
          r_d_gnt <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_i_gnt <= 1'b0;
          r_d_gnt <= 1'b0;
        end
      endcase
    end
  end

  // latch the winner's request at grant; the I side is always a read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_start) begin
      if (w_pick_d) begin
        r_mem_wr    <= d_wr;
        r_mem_addr  <= d_addr;
        r_mem_wdata <= d_wdata;
      end else begin
        r_mem_wr   <= 1'b0;
        r_mem_addr <= i_addr;
      end
    end
  end

  // capture read data on the last BUSY cycle; a D write leaves d_rdata untouched
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else if ((r_state == ST_BUSY) && (r_cnt == LAT)) begin
      if (!r_win_d) begin
        r_i_rdata <= mem_rdata;
      end else if (!r_mem_wr) begin
        r_d_rdata <= mem_rdata;
      end
    end
  end

  assign i_gnt     = r_i_gnt;
  assign d_gnt     = r_d_gnt;
  assign i_done    = r_i_done;
  assign d_done    = r_d_done;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign mem_en    = r_mem_en;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: transaction-level expected-output schedule plus memory responder.
module tb_mem_arb;
  localparam int LAT  = 4;
  localparam int NCYC = 8192;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic        i_gnt, i_done, d_gnt, d_done, mem_en, mem_wr, busy;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  mem_arb #(.MEM_LAT(LAT), .AW(16), .DW(16)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // expected outputs per cycle, filled in when the model grants a request
  bit          eg_i[NCYC], eg_d[NCYC], ee[NCYC], ew[NCYC], edn_i[NCYC], edn_d[NCYC];
  bit          upd_i[NCYC], upd_d[NCYC];
  logic [15:0] ea[NCYC], ewd[NCYC], upd_iv[NCYC], upd_dv[NCYC], exp_ir[NCYC], exp_dr[NCYC];
  logic [15:0] mdl_mem[65536];
  logic [15:0] env_mem[65536];
  int          free_at = 0;
  bit          m_last_d = 1'b0;
  logic [15:0] m_i = '0, m_d = '0;
  int          env_due = -1;
  logic [15:0] env_val = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // one clock: advance to just after the edge, then let the memory respond
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    mem_rdata = (env_due == cyc) ? env_val : 16'($urandom);
    if (mem_en === 1'b1) begin
      if (mem_wr) env_mem[mem_addr] = mem_wdata;
      else begin
        env_due = cyc + LAT;
        env_val = env_mem[mem_addr];
      end
    end
  endtask

  task automatic clr_from(input int c);
    for (int k = c; k < c + 32 && k < NCYC; k++) begin
      eg_i[k] = 0; eg_d[k] = 0; ee[k] = 0; ew[k] = 0; edn_i[k] = 0; edn_d[k] = 0;
      upd_i[k] = 0; upd_d[k] = 0;
    end
  endtask

  // reference model: in a free cycle a pending request is granted and its whole
  // timeline (grant span, strobe, done, data) is written into the schedule
  task automatic mdl();
    int c;
    bit pd, tie_d;
    logic [15:0] a;
    c = cyc;
    if (c >= NCYC - 40) return;
    if (upd_i[c]) m_i = upd_iv[c];
    if (upd_d[c]) m_d = upd_dv[c];
    exp_ir[c] = m_i;
    exp_dr[c] = m_d;
    if (c >= free_at && (i_req || d_req)) begin
`ifdef MEM_ARB_RR_EN
      tie_d = !m_last_d;
`else
      tie_d = 1'b1;
`endif
      pd = d_req && (!i_req || tie_d);
      m_last_d = pd;
      a = pd ? d_addr : i_addr;
      for (int k = c + 1; k <= c + 2 + LAT; k++) begin
        eg_i[k] = !pd;
        eg_d[k] = pd;
      end
      ee[c+1] = 1; ea[c+1] = a; ew[c+1] = pd && d_wr; ewd[c+1] = d_wdata;
      if (pd) edn_d[c+2+LAT] = 1; else edn_i[c+2+LAT] = 1;
      if (pd && d_wr) mdl_mem[a] = d_wdata;
      else if (pd) begin upd_d[c+2+LAT] = 1; upd_dv[c+2+LAT] = mdl_mem[a]; end
      else begin upd_i[c+2+LAT] = 1; upd_iv[c+2+LAT] = mdl_mem[a]; end
      free_at = c + 3 + LAT;
    end
  endtask

  // per-cycle comparison of every output against the schedule
  always @(negedge clk) begin
    if (chk_en && cyc > 0 && cyc < NCYC - 40) begin
      chk("i_gnt", i_gnt, eg_i[cyc]);
      chk("d_gnt", d_gnt, eg_d[cyc]);
      chk("busy", busy, eg_i[cyc] | eg_d[cyc]);
      chk("mem_en", mem_en, ee[cyc]);
      chk("i_done", i_done, edn_i[cyc]);
      chk("d_done", d_done, edn_d[cyc]);
      chk("i_rdata", i_rdata, exp_ir[cyc]);
      chk("d_rdata", d_rdata, exp_dr[cyc]);
      if (ee[cyc]) begin
        chk("mem_addr", mem_addr, ea[cyc]);
        chk("mem_wr", mem_wr, ew[cyc]);
        if (ew[cyc]) chk("mem_wdata", mem_wdata, ewd[cyc]);
      end
    end
  end

  task automatic run_one(input bit is_d, input bit wr, input logic [15:0] a, input logic [15:0] wd,
                         output int en_off, output int dn_off, output int n_en, output bit en_wr,
                         output logic [15:0] en_a, output logic [15:0] en_wd,
                         output logic [15:0] rd, output bit oth);
    int t0;
    en_off = -1; dn_off = -1; n_en = 0; en_wr = 0; en_a = '0; en_wd = '0; rd = '0; oth = 0;
    tick();
    if (is_d) begin d_req = 1; d_wr = wr; d_addr = a; d_wdata = wd; end
    else begin i_req = 1; i_addr = a; end
    t0 = cyc;
    mdl();
    for (int k = 0; k < 30; k++) begin
      tick();
      if (mem_en) begin
        if (n_en == 0) begin en_off = cyc - t0; en_wr = mem_wr; en_a = mem_addr; en_wd = mem_wdata; end
        n_en++;
      end
      if (is_d ? i_gnt : d_gnt) oth = 1;
      if (is_d ? d_done : i_done) begin
        dn_off = cyc - t0;
        rd = is_d ? d_rdata : i_rdata;
        if (is_d) d_req = 0; else i_req = 0;
      end
      mdl();
      if (dn_off >= 0) break;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "bench timed out");
  end

  initial begin
    int eo, dn, ne, t0, nd, nwin, ndone, ovl, idn, dg;
    bit ewr, oth;
    logic [15:0] ead, ewdat, rd;
    logic [3:0] win, win_exp;

    for (int k = 0; k < 65536; k++) begin
      env_mem[k] = 16'($urandom);
      mdl_mem[k] = env_mem[k];
    end
    env_mem[16'h0010] = 16'hBEEF;
    mdl_mem[16'h0010] = 16'hBEEF;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {i_gnt, d_gnt, i_done, d_done, mem_en, mem_wr, busy}, 0);
    chk("reset_data", {mem_addr, mem_wdata, i_rdata, d_rdata}, 0);
    tick();
    rst = 1;
    mdl();
    chk_en = 1;
    tick(); mdl();

    // single I read of 0xBEEF
    run_one(0, 0, 16'h0010, 16'h0, eo, dn, ne, ewr, ead, ewdat, rd, oth);
    chk("i_rd_en_off", eo, 1);
    chk("i_rd_done_off", dn, 6);
    chk("i_rd_data", rd, 16'hBEEF);
    chk("i_rd_no_dgnt", oth, 0);
    chk("i_rd_addr", ead, 16'h0010);

    // D write: d_rdata must keep its reset value
    run_one(1, 1, 16'h0200, 16'h1234, eo, dn, ne, ewr, ead, ewdat, rd, oth);
    chk("d_wr_n_en", ne, 1);
    chk("d_wr_mem_wr", ewr, 1);
    chk("d_wr_addr", ead, 16'h0200);
    chk("d_wr_wdata", ewdat, 16'h1234);
    chk("d_wr_done_off", dn, 6);
    chk("d_wr_rdata_held", rd, 16'h0000);

    // read back what was written
    run_one(1, 0, 16'h0200, 16'h0, eo, dn, ne, ewr, ead, ewdat, rd, oth);
    chk("d_rd_back", rd, 16'h1234);
    chk("d_rd_done_off", dn, 6);

    // reset in the second BUSY cycle of an I read
    tick(); i_req = 1; i_addr = 16'h0030; mdl();
    tick(); mdl();
    tick();
    chk("pre_rst_busy", {busy, i_gnt}, 2'b11);
    mdl();
    chk_en = 0;
    #2 rst = 0;
    #1;
    chk("rst_ctrl", {i_gnt, d_gnt, i_done, d_done, mem_en, mem_wr, busy}, 0);
    chk("rst_data", {mem_addr, mem_wdata, i_rdata, d_rdata}, 0);
    i_req = 0;
    clr_from(cyc);
    m_i = '0; m_d = '0; free_at = 0; m_last_d = 0; env_due = -1;
    nd = 0;
    repeat (3) begin tick(); nd += int'(i_done | d_done); end
    rst = 1;
    mdl();
    chk_en = 1;
    repeat (4) begin tick(); nd += int'(i_done | d_done); mdl(); end
    chk("rst_no_done", nd, 0);
    run_one(0, 0, 16'h0010, 16'h0, eo, dn, ne, ewr, ead, ewdat, rd, oth);
    chk("post_rst_done_off", dn, 6);
    chk("post_rst_data", rd, 16'hBEEF);

    // continuous tie for four transactions
    tick();
    i_req = 1; d_req = 1; d_wr = 0; i_addr = 16'h0040; d_addr = 16'h0041;
    mdl();
    nwin = 0; ndone = 0; ovl = 0; win = '0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (mem_en) begin
        if (nwin < 4) win[nwin] = d_gnt;
        nwin++;
      end
      if (i_gnt && d_gnt) ovl++;
      if (i_done || d_done) ndone++;
      if (ndone == 4) begin i_req = 0; d_req = 0; end
      mdl();
      if (ndone == 4) break;
    end
`ifdef MEM_ARB_RR_EN
    win_exp = 4'b0101;
`else
    win_exp = 4'b1111;
`endif
    chk("tie_order", win, win_exp);
    chk("tie_count", nwin, 4);
    chk("tie_no_overlap", ovl, 0);

    // d_req raised while I is busy waits for the next IDLE cycle
    tick(); i_req = 1; i_addr = 16'h0011; t0 = cyc; mdl();
    idn = -1; dg = -1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (cyc == t0 + 2) begin d_req = 1; d_wr = 0; d_addr = 16'h0010; end
      if (i_done) begin idn = cyc - t0; i_req = 0; end
      if (d_gnt && dg < 0) dg = cyc - t0;
      if (d_done) d_req = 0;
      mdl();
      if (!d_req && dg >= 0) break;
    end
    chk("late_d_i_done", idn, 6);
    chk("late_d_gnt", dg, 8);
    chk("late_d_rdata", d_rdata, 16'hBEEF);

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      tick();
      if (i_done) begin
        if ($urandom_range(0, 2) == 0) i_addr = 16'($urandom_range(0, 63));
        else i_req = 0;
      end else if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req = 1; i_addr = 16'($urandom_range(0, 63));
      end
      if (d_done) begin
        if ($urandom_range(0, 2) == 0) begin
          d_addr = 16'($urandom_range(0, 63)); d_wr = 1'($urandom_range(0, 1)); d_wdata = 16'($urandom);
        end else d_req = 0;
      end else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1; d_addr = 16'($urandom_range(0, 63)); d_wr = 1'($urandom_range(0, 1)); d_wdata = 16'($urandom);
      end
      mdl();
    end
    for (int k = 0; k < 200; k++) begin
      tick();
      if (i_done) i_req = 0;
      if (d_done) d_req = 0;
      mdl();
      if (!i_req && !d_req && !busy) break;
    end
    chk("drain_idle", {i_req, d_req, busy}, 0);
    repeat (3) begin tick(); mdl(); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
